// File: rtl/line_fetch_if.sv
// VRAM read handshake and palette lookup bus between the line fetcher and memory.
interface line_fetch_if;
    logic        vram_req;
    logic [15:0] vram_addr;
    logic        vram_ack;
    logic [15:0] vram_rdata;
    logic [7:0]  palette_addr;
    logic [15:0] palette_data;

    modport master (
        output vram_req,
        output vram_addr,
        output palette_addr,
        input  vram_ack,
        input  vram_rdata,
        input  palette_data
    );

    modport slave (
        input  vram_req,
        input  vram_addr,
        input  palette_addr,
        output vram_ack,
        output vram_rdata,
        output palette_data
    );
endinterface

// File: rtl/line_fetch.sv
// Scanline fetcher: fills one half of a ping-pong line buffer from VRAM (mode 3 direct
// BGR555, mode 4 palettised bytes) while the display reads the other half.
module line_fetch #(
    parameter int unsigned H_PIX = 240,
    parameter int unsigned V_PIX = 160
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         dispcnt,
    input  logic                line_start,
    input  logic [7:0]          line_num,
    line_fetch_if.master        bus,
    input  logic [7:0]          rd_col,
    output logic [14:0]         rd_pixel,
    output logic                busy,
    output logic                overrun
);

    typedef enum logic [1:0] {StIdle, StRd, StP0, StP1} state_e;

    localparam logic [7:0] HLast = 8'(H_PIX - 1);
    localparam logic [8:0] HPix9 = 9'(H_PIX);
    localparam logic [8:0] VPix9 = 9'(V_PIX);

    state_e      state_q, state_d;
    logic        sel_q, sel_d;          // index of the half currently being fetched
    logic [1:0]  valid_q, valid_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  line_q, line_d;
    logic [2:0]  mode_q, mode_d;
    logic        frame_q, frame_d;
    logic [15:0] rdata_q, rdata_d;      // mode-4 pixel pair awaiting palette lookup
    logic [7:0]  pal_addr_q, pal_addr_d;
    logic        overrun_q, overrun_d;
    logic [14:0] rd_pixel_q, rd_pixel_d;

    logic [14:0] mem_q [2][H_PIX];
    logic        we;
    logic [7:0]  widx;
    logic [14:0] wdata;

    logic [15:0] line_w;
    logic [15:0] addr3;
    logic [15:0] addr4;
    logic        start_ok;
    logic        unused_bits;

    assign line_w = {8'd0, line_q};
    assign addr3  = line_w * 16'd240 + {8'd0, x_q};
    assign addr4  = line_w * 16'd120 + {9'd0, x_q[7:1]} + (frame_q ? 16'hA000 : 16'h0000);

    assign start_ok = ((dispcnt[2:0] == 3'd3) || (dispcnt[2:0] == 3'd4)) &&
                      ({1'b0, line_num} < VPix9);

    assign bus.vram_req     = (state_q == StRd);
    assign bus.vram_addr    = (mode_q == 3'd4) ? addr4 : addr3;
    assign bus.palette_addr = pal_addr_q;
    assign rd_pixel         = rd_pixel_q;
    assign busy             = (state_q != StIdle);
    assign overrun          = overrun_q;

    assign unused_bits = ^{dispcnt[15:5], dispcnt[3], bus.palette_data[15]};

    // Next-state: line_start always wins and restarts, otherwise step the fetch FSM.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        x_d        = x_q;
        line_d     = line_q;
        mode_d     = mode_q;
        frame_d    = frame_q;
        rdata_d    = rdata_q;
        pal_addr_d = pal_addr_q;
        overrun_d  = 1'b0;
        we         = 1'b0;
        widx       = x_q;
        wdata      = 15'h0;

        if ((valid_q[~sel_q] == 1'b1) && ({1'b0, rd_col} < HPix9)) begin
            rd_pixel_d = mem_q[~sel_q][rd_col];
        end else begin
            rd_pixel_d = 15'h0;
        end

        if (line_start) begin
            overrun_d       = (state_q != StIdle);
            sel_d           = ~sel_q;
            valid_d[~sel_q] = 1'b0;
            line_d          = line_num;
            mode_d          = dispcnt[2:0];
            frame_d         = dispcnt[4];
            x_d             = 8'd0;
            state_d         = start_ok ? StRd : StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                end
                StRd: begin
                    if (bus.vram_ack) begin
                        if (mode_q == 3'd4) begin
                            rdata_d    = bus.vram_rdata;
                            pal_addr_d = bus.vram_rdata[7:0];
                            state_d    = StP0;
                        end else begin
                            we    = 1'b1;
                            wdata = bus.vram_rdata[14:0];
                            if (x_q == HLast) begin
                                valid_d[sel_q] = 1'b1;
                                state_d        = StIdle;
                            end else begin
                                x_d = x_q + 8'd1;
                            end
                        end
                    end
                end
                StP0: begin
                    we         = 1'b1;
                    wdata      = bus.palette_data[14:0];
                    pal_addr_d = rdata_q[15:8];
                    state_d    = StP1;
                end
                StP1: begin
                    we    = 1'b1;
                    widx  = x_q + 8'd1;
                    wdata = bus.palette_data[14:0];
                    if ((x_q + 8'd1) == HLast) begin
                        valid_d[sel_q] = 1'b1;
                        state_d        = StIdle;
                    end else begin
                        x_d     = x_q + 8'd2;
                        state_d = StRd;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sel_q      <= 1'b0;
            valid_q    <= 2'b00;
            x_q        <= 8'd0;
            line_q     <= 8'd0;
            mode_q     <= 3'd0;
            frame_q    <= 1'b0;
            rdata_q    <= 16'h0;
            pal_addr_q <= 8'd0;
            overrun_q  <= 1'b0;
            rd_pixel_q <= 15'h0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            x_q        <= x_d;
            line_q     <= line_d;
            mode_q     <= mode_d;
            frame_q    <= frame_d;
            rdata_q    <= rdata_d;
            pal_addr_q <= pal_addr_d;
            overrun_q  <= overrun_d;
            rd_pixel_q <= rd_pixel_d;
        end
    end

    // Line buffer write port; contents survive reset but no write lands during it.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            mem_q[sel_q][widx] <= wdata;
        end
    end

endmodule

// File: tb/tb_line_fetch.sv
// Directed bench for line_fetch with a VRAM responder (configurable stall) and palette model.
module tb_line_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dispcnt;
    logic        line_start;
    logic [7:0]  line_num;
    logic [7:0]  rd_col;
    logic [14:0] rd_pixel;
    logic        busy;
    logic        overrun;

    int          errors = 0;
    int          checks = 0;
    int          stall_cfg = 0;
    int          ack_cnt = 0;
    int          stall_viol = 0;
    logic [15:0] q_addr[$];

    line_fetch_if bus ();

    line_fetch #(.H_PIX(240), .V_PIX(160)) dut (
        .clk        (clk),
        .rst        (rst),
        .dispcnt    (dispcnt),
        .line_start (line_start),
        .line_num   (line_num),
        .bus        (bus),
        .rd_col     (rd_col),
        .rd_pixel   (rd_pixel),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] vram_val(input logic [15:0] a);
        return (a == 16'hA000) ? 16'h0201 : a;
    endfunction

    function automatic logic [15:0] pal_val(input logic [7:0] a);
        if (a == 8'd1) return 16'h7C00;
        if (a == 8'd2) return 16'h03E0;
        return 16'h5500 ^ {8'h00, a};
    endfunction

    assign bus.palette_data = pal_val(bus.palette_addr);

    // VRAM responder: grants after stall_cfg wait cycles, data is junk except on ack.
    initial begin
        int          wait_cnt;
        logic        pend;
        logic [15:0] pend_addr;
        wait_cnt       = 0;
        pend           = 1'b0;
        pend_addr      = 16'h0;
        bus.vram_ack   = 1'b0;
        bus.vram_rdata = 16'h7FFF;
        forever begin
            @(negedge clk);
            if (pend && !(bus.vram_req && bus.vram_addr == pend_addr)) stall_viol++;
            if (bus.vram_req) begin
                if (wait_cnt >= stall_cfg) begin
                    bus.vram_ack   = 1'b1;
                    bus.vram_rdata = vram_val(bus.vram_addr);
                    ack_cnt++;
                    q_addr.push_back(bus.vram_addr);
                    wait_cnt = 0;
                    pend     = 1'b0;
                end else begin
                    bus.vram_ack   = 1'b0;
                    bus.vram_rdata = 16'h7FFF;
                    wait_cnt++;
                    pend      = 1'b1;
                    pend_addr = bus.vram_addr;
                end
            end else begin
                bus.vram_ack   = 1'b0;
                bus.vram_rdata = 16'h7FFF;
                wait_cnt       = 0;
                pend           = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] n);
        line_num   = n;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_seq(input string tag, input logic [15:0] base, input int n);
        int bad;
        bad = 0;
        chk({tag, "_count"}, q_addr.size(), n);
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_addr[i] !== 16'(base + 16'(i))) bad++;
        end
        chk({tag, "_addr_seq"}, bad, 32'd0);
    endtask

    task automatic read_chk(input string tag, input logic [7:0] col, input logic [14:0] exp);
        rd_col = col;
        step();
        chk(tag, {17'd0, rd_pixel}, {17'd0, exp});
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_vram_req"}, {31'd0, bus.vram_req}, 32'd0);
        chk({tag, "_vram_addr"}, {16'd0, bus.vram_addr}, 32'd0);
        chk({tag, "_palette_addr"}, {24'd0, bus.palette_addr}, 32'd0);
        chk({tag, "_rd_pixel"}, {17'd0, rd_pixel}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        int base;
        int n;
        rst        = 1'b1;
        dispcnt    = 16'h0000;
        line_start = 1'b0;
        line_num   = 8'd0;
        rd_col     = 8'd0;
        step();
        step();
        reset_checks("reset");
        rst = 1'b0;
        step();

        // Mode 3, line 2, ack every cycle
        dispcnt = 16'h0003;
        q_addr.delete();
        pulse(8'd2);
        wait_idle(2000, "m3_timeout");
        check_seq("m3", 16'd480, 240);
        dispcnt = 16'h0000;
        pulse(8'd0);
        step();
        chk("mode0_busy", {31'd0, busy}, 32'd0);
        chk("mode0_req", {31'd0, bus.vram_req}, 32'd0);
        read_chk("m3_col5", 8'd5, 15'h01E5);
        read_chk("m3_col239", 8'd239, 15'h02CF);
        read_chk("m3_col240", 8'd240, 15'h0000);

        // Mode 4, frame 1, line 0; dispcnt changed mid-fetch must not matter
        dispcnt = 16'h0014;
        q_addr.delete();
        pulse(8'd0);
        repeat (20) step();
        dispcnt = 16'h0003;
        wait_idle(2000, "m4_timeout");
        check_seq("m4", 16'hA000, 120);
        dispcnt = 16'h0000;
        pulse(8'd0);
        read_chk("m4_pix0", 8'd0, 15'h7C00);
        read_chk("m4_pix1", 8'd1, 15'h03E0);
        read_chk("m4_pix2", 8'd2, 15'h7C00);
        read_chk("m4_pix3", 8'd3, 15'h55A0);

        // Mode 3, line 1, every request stalled 5 cycles
        stall_cfg = 5;
        dispcnt   = 16'h0003;
        q_addr.delete();
        pulse(8'd1);
        wait_idle(5000, "stall_timeout");
        chk("stall_stable", stall_viol, 32'd0);
        check_seq("stall", 16'd240, 240);
        stall_cfg = 0;
        dispcnt   = 16'h0000;
        pulse(8'd0);
        read_chk("stall_col7", 8'd7, 15'h00F7);

        // Overrun: restart mid-fetch of line 3 with line 4
        dispcnt = 16'h0003;
        pulse(8'd3);
        base = ack_cnt;
        n    = 0;
        while ((ack_cnt - base) < 101 && n < 1000) begin
            step();
            n++;
        end
        chk("ovr_reach_x100", ack_cnt - base, 32'd101);
        q_addr.delete();
        pulse(8'd4);
        chk("ovr_pulse", {31'd0, overrun}, 32'd1);
        rd_col = 8'd5;
        step();
        chk("ovr_once", {31'd0, overrun}, 32'd0);
        chk("ovr_display_invalid", {17'd0, rd_pixel}, 32'd0);
        wait_idle(2000, "ovr_timeout");
        check_seq("ovr_restart", 16'd960, 240);

        // Out-of-range line: no fetch, second swap exposes an invalid half
        dispcnt = 16'h0003;
        q_addr.delete();
        pulse(8'd160);
        step();
        chk("l160_busy", {31'd0, busy}, 32'd0);
        chk("l160_req", {31'd0, bus.vram_req}, 32'd0);
        chk("l160_no_acks", q_addr.size(), 32'd0);
        pulse(8'd160);
        read_chk("l160_rd", 8'd5, 15'h0000);

        // Reset in the middle of a mode-4 fetch
        dispcnt = 16'h0014;
        pulse(8'd0);
        repeat (11) step();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        reset_checks("rst_mid");
        rst = 1'b0;
        dispcnt = 16'h0000;
        pulse(8'd0);
        read_chk("rst_valid_cleared", 8'd5, 15'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
